// File: rtl/lut_neuron_table_loader_if.sv
// lut_neuron_table_loader_if: config stream and lookup signals of the runtime-programmable LUT neuron
//   cfg_start  : pulse, (re)start loading the table from entry 0
//   cfg_valid  : config beat valid
//   cfg_data   : config beat, entry k at [k*OUT_BITS +: OUT_BITS]
//   cfg_ready  : block accepts a beat (LOAD only)
//   cfg_done   : 1-cycle pulse after the last beat is written
//   table_ok   : table fully programmed, lookups enabled
//   M0_valid/M0: lookup request and address
//   M1_valid/M1: registered lookup result
//   M0_drop    : 1-cycle pulse, a lookup arrived outside RUN and was discarded
interface lut_neuron_table_loader_if #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 2,
    parameter int LOAD_W   = 32
);
    logic                cfg_start;
    logic                cfg_valid;
    logic [LOAD_W-1:0]   cfg_data;
    logic                cfg_ready;
    logic                cfg_done;
    logic                table_ok;
    logic                M0_valid;
    logic [IN_BITS-1:0]  M0;
    logic                M1_valid;
    logic [OUT_BITS-1:0] M1;
    logic                M0_drop;

    modport master (
        output cfg_start, cfg_valid, cfg_data, M0_valid, M0,
        input  cfg_ready, cfg_done, table_ok, M1_valid, M1, M0_drop
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_data, M0_valid, M0,
        output cfg_ready, cfg_done, table_ok, M1_valid, M1, M0_drop
    );
endinterface

// File: rtl/lut_neuron_table_loader.sv
// lut_neuron_table_loader: serially loaded RAM truth table answering single-cycle LUT neuron lookups
//   clk : clock
//   rst : asynchronous reset, active-high
//   bus : lut_neuron_table_loader_if.slave (config stream in, lookup request in, lookup result out)
module lut_neuron_table_loader #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 2,
    parameter int LOAD_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    lut_neuron_table_loader_if.slave  bus
);
    localparam int EPB      = LOAD_W / OUT_BITS;
    localparam int EPB_BITS = $clog2(EPB);
    localparam int CNT_W    = IN_BITS - EPB_BITS;
    localparam int BEATS    = 2 ** CNT_W;

    typedef enum logic [1:0] {UNPROG, LOAD, RUN} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ready_q, done_q, ok_q, m1_valid_q, drop_q;
    logic [OUT_BITS-1:0] m1_q, rd;
    logic [LOAD_W-1:0]   mem [BEATS];
    logic [LOAD_W-1:0]   rd_beat;
    logic                accept, last, run_lookup;

    // cfg_start wins over a simultaneous beat, so that beat is never written
    assign accept     = state_q == LOAD && bus.cfg_valid && ready_q && !bus.cfg_start;
    // terminal beat is all-ones in the counter, so the counter never has to wrap
    assign last       = &cnt_q;
    assign run_lookup = bus.M0_valid && state_q == RUN;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.cfg_start) begin
            state_d = LOAD;
            cnt_d   = '0;
        end else if (accept) begin
            state_d = last ? RUN : LOAD;
            cnt_d   = last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= UNPROG;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            m1_valid_q <= 1'b0;
            drop_q     <= 1'b0;
            m1_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= state_d == LOAD;
            ok_q       <= state_d == RUN;
            done_q     <= accept && last;
            m1_valid_q <= run_lookup;
            drop_q     <= bus.M0_valid && state_q != RUN;
            if (run_lookup) m1_q <= rd;
        end
    end

    // Writes happen only in LOAD and reads only in RUN, so a lookup never sees a partial table
    always_ff @(posedge clk) begin
        if (accept) mem[cnt_q] <= bus.cfg_data;
    end

    always_comb begin
        rd_beat = mem[bus.M0[IN_BITS-1:EPB_BITS]];
        rd      = '0;
        for (int k = 0; k < EPB; k++)
            if (bus.M0[EPB_BITS-1:0] == EPB_BITS'(k)) rd = rd_beat[k*OUT_BITS +: OUT_BITS];
    end

    assign bus.cfg_ready = ready_q;
    assign bus.cfg_done  = done_q;
    assign bus.table_ok  = ok_q;
    assign bus.M1_valid  = m1_valid_q;
    assign bus.M1        = m1_q;
    assign bus.M0_drop   = drop_q;
endmodule

// File: tb/tb_lut_neuron_table_loader.sv
// tb_lut_neuron_table_loader: directed checks of loading, lookups, restarts and reset of the LUT neuron
module tb_lut_neuron_table_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_run = 0;
    int   n_fail = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    lut_neuron_table_loader_if bus ();

    lut_neuron_table_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge
    task automatic step();
        @(negedge clk);
        if (bus.cfg_done) done_cnt++;
    endtask

    // mode 0: all 2'b11, 1: entry i = i[1:0], 2: entries of beat b = b[1:0], 3: = ~b[1:0]
    function automatic logic [31:0] beat(input int mode, input int b);
        logic [1:0] v;
        v = 2'(b);
        case (mode)
            0:       return 32'hFFFF_FFFF;
            1:       return 32'hE4E4_E4E4;
            2:       return {16{v}};
            default: return {16{~v}};
        endcase
    endfunction

    task automatic start();
        bus.cfg_start = 1'b1;
        step();
        bus.cfg_start = 1'b0;
        chk("ready_load", bus.cfg_ready, 1);
        chk("ok_load", bus.table_ok, 0);
    endtask

    task automatic load(input int mode, input bit gaps, input bit probe);
        done_cnt = 0;
        for (int b = 0; b < 16; b++) begin
            if (gaps) repeat ($urandom_range(0, 2)) step();
            bus.cfg_valid = 1'b1;
            bus.cfg_data  = beat(mode, b);
            if (probe && b == 15) begin
                bus.M0_valid = 1'b1;
                bus.M0       = 8'hCA;
            end
            step();
            bus.cfg_valid = 1'b0;
            bus.M0_valid  = 1'b0;
            if (b == 14) chk("done_early", done_cnt, 0);
        end
        chk("done_last", bus.cfg_done, 1);
        chk("ok_last", bus.table_ok, 1);
        if (probe) begin
            chk("drop_last", bus.M0_drop, 1);
            chk("m1v_last", bus.M1_valid, 0);
        end
        step();
        chk("done_cnt", done_cnt, 1);
        chk("done_pulse", bus.cfg_done, 0);
        chk("ready_run", bus.cfg_ready, 0);
    endtask

    task automatic look(input string tag, input logic [7:0] a, input logic [1:0] exp);
        bus.M0_valid = 1'b1;
        bus.M0       = a;
        step();
        bus.M0_valid = 1'b0;
        chk({tag, "_v"}, bus.M1_valid, 1);
        chk(tag, bus.M1, exp);
    endtask

    initial begin
        bus.cfg_start = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = '0;
        bus.M0_valid  = 1'b0;
        bus.M0        = '0;
        repeat (2) step();
        chk("rst_ready", bus.cfg_ready, 0);
        chk("rst_done", bus.cfg_done, 0);
        chk("rst_ok", bus.table_ok, 0);
        chk("rst_m1v", bus.M1_valid, 0);
        chk("rst_m1", bus.M1, 0);
        chk("rst_drop", bus.M0_drop, 0);
        rst = 1'b0;

        // lookup before programming is dropped
        bus.M0_valid = 1'b1;
        bus.M0       = 8'h00;
        step();
        bus.M0_valid = 1'b0;
        chk("t1_m1v", bus.M1_valid, 0);
        chk("t1_drop", bus.M0_drop, 1);
        chk("t1_ok", bus.table_ok, 0);
        step();
        chk("t1_drop_pulse", bus.M0_drop, 0);
        bus.cfg_valid = 1'b1;
        step();
        bus.cfg_valid = 1'b0;
        chk("t1_ready", bus.cfg_ready, 0);

        // all-ones table, back-to-back beats
        start();
        load(0, 1'b0, 1'b0);
        look("t2_00", 8'h00, 2'b11);
        look("t2_7f", 8'h7F, 2'b11);
        look("t2_ff", 8'hFF, 2'b11);

        // restart with a simultaneous beat at beat 7
        start();
        for (int b = 0; b < 7; b++) begin
            bus.cfg_valid = 1'b1;
            bus.cfg_data  = beat(1, b);
            step();
        end
        bus.cfg_start = 1'b1;
        bus.cfg_data  = 32'h0;
        step();
        bus.cfg_start = 1'b0;
        bus.cfg_valid = 1'b0;
        chk("t4_ready", bus.cfg_ready, 1);
        load(2, 1'b0, 1'b0);
        look("t4_75", 8'h75, 2'b11);
        look("t4_20", 8'h20, 2'b10);
        look("t4_10", 8'h10, 2'b01);
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = 32'hFFFF_FFFF;
        step();
        bus.cfg_valid = 1'b0;
        chk("t4_ready17", bus.cfg_ready, 0);
        look("t4_05", 8'h05, 2'b00);

        // entry i = i[1:0] with gaps, then streamed lookups
        start();
        load(1, 1'b1, 1'b0);
        bus.M0_valid = 1'b1;
        bus.M0       = 8'hCA;
        step();
        chk("t3_ca_v", bus.M1_valid, 1);
        chk("t3_ca", bus.M1, 2'b10);
        bus.M0 = 8'h0F;
        step();
        chk("t3_0f_v", bus.M1_valid, 1);
        chk("t3_0f", bus.M1, 2'b11);
        bus.M0 = 8'h05;
        step();
        chk("t3_05_v", bus.M1_valid, 1);
        chk("t3_05", bus.M1, 2'b01);
        bus.M0_valid = 1'b0;
        step();
        chk("t3_idle_v", bus.M1_valid, 0);
        chk("t3_hold", bus.M1, 2'b01);
        chk("t3_nodrop", bus.M0_drop, 0);

        // reload while looking up: old table serves the start cycle
        bus.cfg_start = 1'b1;
        bus.M0_valid  = 1'b1;
        bus.M0        = 8'hCA;
        step();
        bus.cfg_start = 1'b0;
        bus.M0        = 8'h0F;
        chk("t5_m1v", bus.M1_valid, 1);
        chk("t5_m1", bus.M1, 2'b10);
        chk("t5_ok", bus.table_ok, 0);
        chk("t5_ready", bus.cfg_ready, 1);
        step();
        bus.M0_valid = 1'b0;
        chk("t5_drop", bus.M0_drop, 1);
        chk("t5_m1v_load", bus.M1_valid, 0);
        chk("t5_hold", bus.M1, 2'b10);
        load(3, 1'b0, 1'b1);
        look("t5_ca", 8'hCA, 2'b11);
        look("t5_35", 8'h35, 2'b00);

        // reset in the middle of a load
        start();
        for (int b = 0; b < 9; b++) begin
            bus.cfg_valid = 1'b1;
            bus.cfg_data  = beat(1, b);
            bus.M0_valid  = b == 8;
            step();
        end
        bus.M0_valid = 1'b0;
        chk("t6_drop_pend", bus.M0_drop, 1);
        rst = 1'b1;
        #1;
        chk("t6_ready", bus.cfg_ready, 0);
        chk("t6_ok", bus.table_ok, 0);
        chk("t6_drop", bus.M0_drop, 0);
        chk("t6_m1v", bus.M1_valid, 0);
        chk("t6_done", bus.cfg_done, 0);
        chk("t6_m1", bus.M1, 0);
        step();
        rst = 1'b0;
        repeat (2) step();
        bus.cfg_valid = 1'b0;
        chk("t6_ign_ready", bus.cfg_ready, 0);
        chk("t6_ign_ok", bus.table_ok, 0);
        bus.M0_valid = 1'b1;
        bus.M0       = 8'hCA;
        step();
        bus.M0_valid = 1'b0;
        chk("t6_unprog_drop", bus.M0_drop, 1);
        start();
        load(1, 1'b0, 1'b0);
        look("t6_ca", 8'hCA, 2'b10);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
